pipe_serializer: RTL
====================

PIPE_SERIALIZER -- requirements
Module: pipe_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning the width of the message input.
REQ-002 SHALL have parameter WORD_W, default 32, meaning the width of an output word; MAX_WORDS = DATA_W/WORD_W = 4.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port nRST, input, 1, asynchronous active-high reset (asserted = 1).
REQ-005 SHALL have port in$enq__ENA, input, 1, meaning the upstream message is valid this cycle.
REQ-006 SHALL have port in$enq$v, input, DATA_W, meaning the message; word k = bits [32k+31:32k]; header word0[15:0] = length in words (header included).
REQ-007 SHALL have port in$enq__RDY, output, 1, meaning the block can accept a message this cycle.
REQ-008 SHALL have port out$enq__ENA, output, 1, meaning an output word is transferred this cycle.
REQ-009 SHALL have port out$enq$v, output, WORD_W, meaning the current output word.
REQ-010 SHALL have port out$enq__RDY, input, 1, meaning the downstream host FIFO can take a word.
REQ-011 SHALL have port len_err, output, 1, a one-cycle pulse on accepting a message whose length field is 0 or greater than MAX_WORDS.

Function
REQ-012 SHALL implement two states: IDLE and SEND; reset state is IDLE.
REQ-013 SHALL capture in$enq$v into a message register and enter SEND on a cycle with in$enq__ENA & in$enq__RDY.
REQ-014 SHALL clamp the effective length: a length field of 0 becomes 1, and a length field greater than MAX_WORDS becomes MAX_WORDS; len_err pulses in the cycle after capture.
REQ-015 SHALL hold a word index (2 bits), cleared on capture, which selects out$enq$v = message word[index].
REQ-016 SHALL drive out$enq__ENA = (state == SEND) & out$enq__RDY, with no dependency on in$enq__ENA.
REQ-017 SHALL increment the index on every out$enq__ENA; on the transfer of word (effective length - 1) it shall return to IDLE.
REQ-018 SHALL drive in$enq__RDY = IDLE | (SEND & last word & out$enq__RDY), permitting back-to-back messages with no bubble.
REQ-019 SHALL, when a new capture coincides with a last-word transfer, load the new message, clear the index, and remain in SEND.
REQ-020 SHALL have a latency of one cycle: a message accepted in cycle N presents word0 in cycle N+1.
REQ-021 SHALL hold out$enq$v stable while in SEND with out$enq__RDY low.
REQ-022 SHALL ignore in$enq__ENA when in$enq__RDY is low; no state change results.

Reset
REQ-023 SHALL, on nRST assertion at any time, including mid-message, immediately force state IDLE, index 0, message register 0, len_err 0, out$enq__ENA 0, and out$enq$v 0; a partially sent message is discarded.
REQ-024 SHALL drive in$enq__RDY high in the first cycle after nRST deasserts.

Configuration
REQ-025 SHALL, with SERIALIZER_STATS_EN defined, add a 32-bit output msg_count (incremented per accepted message) and a 16-bit output err_count (incremented per len_err, saturating at 16'hFFFF); both reset to 0 and msg_count wraps.
REQ-026 SHALL, without SERIALIZER_STATS_EN, omit these ports and their registers entirely.

Structure
REQ-027 SHALL obtain the state enum, the header length-field bit positions (15:0), and MAX_WORDS from a shared package pipe_msg_pkg, which is reused by the upstream M2P encoders.
REQ-028 SHALL be a single flat module with no sub-module.

Verification
REQ-029 Message with length 2 and words {0,0,0xDEADBEEF,0x00000002}, out$enq__RDY=1 -> 0x00000002 in cycle N+1, 0xDEADBEEF in cycle N+2, and in$enq__RDY high in cycle N+2.
REQ-030 Two back-to-back length-4 messages with out$enq__RDY held at 1 -> 8 consecutive out$enq__ENA cycles with no gap, in word order.
REQ-031 Length-4 message with out$enq__RDY low for 3 cycles after word1 -> word1 is held stable, no duplicate or lost words, 4 transfers total.
REQ-032 Length field 0x7FFF -> exactly 4 words sent and a single len_err pulse; length field 0 -> only the header word is sent and len_err pulses.
REQ-033 nRST asserted after word1 of a length-4 message -> outputs are 0 asynchronously; after release, a new length-2 message streams correctly.
REQ-034 With SERIALIZER_STATS_EN defined, 3 good messages and 1 bad message -> msg_count = 4 and err_count = 1.

Source files
------------

// File: rtl/pipe_msg_pkg.sv
// Shared message-format definitions for the M2P encoders and the pipe serializer.
package pipe_msg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } msg_state_e;

  localparam int unsigned LEN_LSB   = 0;
  localparam int unsigned LEN_MSB   = 15;
  localparam int unsigned MAX_WORDS = 4;

  // Index of the final word to send once the header length is clamped to 1..MAX_WORDS.
  function automatic logic [1:0] last_index(input logic [15:0] len);
    if (len == 16'd0)
      return 2'd0;
    else if (len > 16'(MAX_WORDS))
      return 2'(MAX_WORDS - 1);
    else
      return 2'(len - 16'd1);
  endfunction

  function automatic logic len_bad(input logic [15:0] len);
    return (len == 16'd0) || (len > 16'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/pipe_serializer.sv
// Splits a header-prefixed message into WORD_W words for a host FIFO.
// Optional SERIALIZER_STATS_EN adds msg_count / err_count statistics outputs.
module pipe_serializer
  import pipe_msg_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_enq__ENA,
  input  logic [DATA_W-1:0] in_enq_v,
  output logic              in_enq__RDY,
  output logic              out_enq__ENA,
  output logic [WORD_W-1:0] out_enq_v,
  input  logic              out_enq__RDY,
  output logic              len_err
`ifdef SERIALIZER_STATS_EN
  ,
  output logic [31:0]       msg_count,
  output logic [15:0]       err_count
`endif
);

  msg_state_e        state;
  logic [DATA_W-1:0] msg;
  logic [1:0]        idx;
  logic [1:0]        last_idx;
  logic [15:0]       hdr_len;
  logic              last_word;
  logic              capture;

  assign hdr_len      = in_enq_v[LEN_MSB:LEN_LSB];
  assign last_word    = (idx == last_idx);
  assign out_enq__ENA = (state == SEND) && out_enq__RDY;
  assign in_enq__RDY  = (state == IDLE) || ((state == SEND) && last_word && out_enq__RDY);
  assign capture      = in_enq__ENA && in_enq__RDY;
  assign out_enq_v    = msg[32'(idx) * WORD_W +: WORD_W];

  // A capture during the last-word transfer takes priority, giving back-to-back messages.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state    <= IDLE;
      msg      <= '0;
      idx      <= '0;
      last_idx <= '0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (capture) begin
        state    <= SEND;
        msg      <= in_enq_v;
        idx      <= '0;
        last_idx <= last_index(hdr_len);
        len_err  <= len_bad(hdr_len);
      end else if (out_enq__ENA) begin
        if (last_word)
          state <= IDLE;
        else
          idx <= idx + 2'd1;
      end
    end
  end

`ifdef SERIALIZER_STATS_EN
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      msg_count <= '0;
      err_count <= '0;
    end else begin
      if (capture)
        msg_count <= msg_count + 32'd1;
      if (len_err && (err_count != '1))
        err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
